// File: rtl/wash_cycle_sequencer.sv
// Wash program sequencer: fill/wash/drain/rinse/spin timed FSM driving the
// command code and operand of the downstream command-processing stage.
//
// state   | meaning
// IDLE    | waiting for start with door closed and a legal program
// FILL    | filling drum, guarded by fill timeout
// WASH    | agitating at wash speed, timed (doubled for heavy)
// DRAIN   | pumping out until water_empty
// RINSE   | agitating at rinse speed, timed
// SPIN    | high-speed spin, timed
// PAUSE   | user pause or door open; timer frozen, return state saved
// DONE    | one-cycle completion pulse
// ERROR   | fill timeout, held until reset
module wash_cycle_sequencer #(
   parameter int          TICK_DIV     = 16,
   parameter int          WASH_TICKS   = 20,
   parameter int          RINSE_TICKS  = 10,
   parameter int          SPIN_TICKS   = 8,
   parameter int          FILL_TIMEOUT = 30,
   parameter logic [7:0]  FILL_LEVEL   = 8'h40,
   parameter logic [7:0]  WASH_SPEED   = 8'h20,
   parameter logic [7:0]  RINSE_SPEED  = 8'h18,
   parameter logic [7:0]  SPIN_SPEED   = 8'hC0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] program_sel,
   input  logic       door_closed,
   input  logic       pause,
   input  logic       water_full,
   input  logic       water_empty,
   output logic [2:0] ctrl,
   output logic [7:0] cmd_data,
   output logic [2:0] phase,
   output logic       busy,
   output logic       door_lock,
   output logic       done,
   output logic       error
);

   typedef enum logic [3:0] {
      S_IDLE, S_FILL, S_WASH, S_DRAIN, S_RINSE, S_SPIN, S_PAUSE, S_DONE, S_ERROR
   } state_t;

   localparam int             PW       = $clog2(TICK_DIV);
   localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);

   state_t        state, state_nx, ret_state;
   logic [15:0]   timer, load_val;
   logic [PW-1:0] prescaler;
   logic [1:0]    rinses_left;
   logic          heavy, wash_done;
   logic          hold_req, timed, tick, entering;
   logic [2:0]    ctrl_nx, phase_nx;
   logic [7:0]    data_nx;
   logic          busy_nx, lock_nx, done_nx, error_nx;

   assign hold_req = pause | ~door_closed;
   assign timed    = (state == S_FILL) || (state == S_WASH) ||
                     (state == S_RINSE) || (state == S_SPIN);
   assign tick     = (prescaler == PRE_LAST);
   // A pause round trip keeps the frozen timer; only real phase changes reload it.
   assign entering = (state_nx != state) && (state != S_PAUSE) && (state_nx != S_PAUSE);

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:
            if (start && door_closed && (program_sel != 2'b11)) state_nx = S_FILL;
         S_FILL, S_WASH, S_DRAIN, S_RINSE, S_SPIN: begin
            if (hold_req) begin
               state_nx = S_PAUSE;
            end else begin
               case (state)
                  S_FILL:
                     if (water_full)        state_nx = wash_done ? S_RINSE : S_WASH;
                     else if (timer == '0)  state_nx = S_ERROR;
                  S_WASH, S_RINSE:
                     if (timer == '0)       state_nx = S_DRAIN;
                  S_DRAIN:
                     if (water_empty)       state_nx = (rinses_left != 2'd0) ? S_FILL : S_SPIN;
                  S_SPIN:
                     if (timer == '0)       state_nx = S_DONE;
                  default: state_nx = state;
               endcase
            end
         end
         S_PAUSE:
            if (!hold_req) state_nx = ret_state;
         S_DONE:  state_nx = S_IDLE;
         S_ERROR: state_nx = S_ERROR;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      load_val = '0;
      case (state_nx)
         S_FILL:  load_val = 16'(FILL_TIMEOUT);
         S_WASH:  load_val = heavy ? 16'(2 * WASH_TICKS) : 16'(WASH_TICKS);
         S_RINSE: load_val = 16'(RINSE_TICKS);
         S_SPIN:  load_val = 16'(SPIN_TICKS);
         default: load_val = '0;
      endcase
   end

   always_comb begin
      ctrl_nx  = 3'b000;
      data_nx  = 8'h00;
      phase_nx = 3'd0;
      busy_nx  = 1'b0;
      lock_nx  = 1'b0;
      done_nx  = 1'b0;
      error_nx = 1'b0;
      case (state_nx)
         S_FILL:  begin ctrl_nx = 3'b001; data_nx = FILL_LEVEL;  phase_nx = 3'd1; busy_nx = 1'b1; lock_nx = 1'b1; end
         S_WASH:  begin ctrl_nx = 3'b010; data_nx = WASH_SPEED;  phase_nx = 3'd2; busy_nx = 1'b1; lock_nx = 1'b1; end
         S_DRAIN: begin                                          phase_nx = 3'd3; busy_nx = 1'b1; lock_nx = 1'b1; end
         S_RINSE: begin ctrl_nx = 3'b010; data_nx = RINSE_SPEED; phase_nx = 3'd4; busy_nx = 1'b1; lock_nx = 1'b1; end
         S_SPIN:  begin ctrl_nx = 3'b011; data_nx = SPIN_SPEED;  phase_nx = 3'd5; busy_nx = 1'b1; lock_nx = 1'b1; end
         S_PAUSE: begin phase_nx = 3'd6; busy_nx = 1'b1; end
         S_DONE:  begin phase_nx = 3'd7; done_nx = 1'b1; end
         S_ERROR: begin phase_nx = 3'd7; error_nx = 1'b1; end
         default: phase_nx = 3'd0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         ret_state   <= S_IDLE;
         timer       <= '0;
         prescaler   <= '0;
         rinses_left <= 2'd0;
         heavy       <= 1'b0;
         wash_done   <= 1'b0;
         ctrl        <= 3'b000;
         cmd_data    <= 8'h00;
         phase       <= 3'd0;
         busy        <= 1'b0;
         door_lock   <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         state     <= state_nx;
         ctrl      <= ctrl_nx;
         cmd_data  <= data_nx;
         phase     <= phase_nx;
         busy      <= busy_nx;
         door_lock <= lock_nx;
         done      <= done_nx;
         error     <= error_nx;

         if (state_nx == S_PAUSE && state != S_PAUSE) ret_state <= state;

         // program code 00/01/10 equals the rinse count directly
         if (state == S_IDLE && state_nx == S_FILL) begin
            rinses_left <= program_sel;
            heavy       <= (program_sel == 2'b10);
            wash_done   <= 1'b0;
         end
         if (state == S_WASH && state_nx == S_DRAIN)  wash_done   <= 1'b1;
         if (state == S_RINSE && state_nx == S_DRAIN) rinses_left <= rinses_left - 2'd1;

         if (entering) begin
            prescaler <= '0;
            timer     <= load_val;
         end else if (state_nx == state && timed && timer != '0) begin
            if (tick) begin
               prescaler <= '0;
               timer     <= timer - 16'd1;
            end else begin
               prescaler <= prescaler + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Bench for wash_cycle_sequencer: vector table, directed corner sequences,
// then random stimulus against a step-list reference model.
module tb_wash_cycle_sequencer;

   localparam int TD = 4, WT = 3, RT = 2, ST = 2, FT = 2;

   logic       clk = 1'b0;
   logic       rst, start, door_closed, pause, water_full, water_empty;
   logic [1:0] program_sel;
   logic [2:0] ctrl, phase;
   logic [7:0] cmd_data;
   logic       busy, door_lock, done, error;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   wash_cycle_sequencer #(
      .TICK_DIV(TD), .WASH_TICKS(WT), .RINSE_TICKS(RT), .SPIN_TICKS(ST), .FILL_TIMEOUT(FT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .program_sel(program_sel),
      .door_closed(door_closed), .pause(pause), .water_full(water_full),
      .water_empty(water_empty), .ctrl(ctrl), .cmd_data(cmd_data), .phase(phase),
      .busy(busy), .door_lock(door_lock), .done(done), .error(error)
   );

   wire [17:0] act = {ctrl, cmd_data, phase, busy, door_lock, done, error};

   function automatic logic [17:0] ev(int ph, int c, int d, bit b, bit l, bit dn, bit e);
      return {3'(c), 8'(d), 3'(ph), b, l, dn, e};
   endfunction

   task automatic check_vec(string name, logic [17:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got outputs %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      start = 0; program_sel = 2'd0; door_closed = 1; pause = 0;
      water_full = 0; water_empty = 0;
   endtask

   // ---------------- reference model: program as a list of phase steps
   int m_mode;   // 0 idle, 1 running, 2 paused, 3 done, 4 error
   int m_steps[$];
   int m_idx, m_el;
   bit m_heavy;

   function automatic int dur(int code);
      if (code == 2) return (m_heavy ? 2 : 1) * WT * TD;
      if (code == 4) return RT * TD;
      return ST * TD;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_steps.delete(); m_idx = 0; m_el = 0; m_heavy = 0;
   endtask

   task automatic model_step();
      int cur;
      bit adv;
      case (m_mode)
         0: if (start && door_closed && program_sel != 2'd3) begin
               m_steps = {1, 2, 3};
               for (int k = 0; k < int'(program_sel); k++) begin
                  m_steps.push_back(1); m_steps.push_back(4); m_steps.push_back(3);
               end
               m_steps.push_back(5);
               m_heavy = (program_sel == 2'd2);
               m_idx = 0; m_el = 0; m_mode = 1;
            end
         1: if (pause || !door_closed) m_mode = 2;
            else begin
               cur = m_steps[m_idx];
               adv = 0;
               if (cur == 1) begin
                  if (water_full) adv = 1;
                  else if (m_el == FT * TD) m_mode = 4;
                  else m_el++;
               end else if (cur == 3) begin
                  adv = water_empty;
               end else begin
                  if (m_el == dur(cur)) adv = 1;
                  else m_el++;
               end
               if (adv) begin
                  m_idx++; m_el = 0;
                  if (m_idx == m_steps.size()) m_mode = 3;
               end
            end
         2: if (!pause && door_closed) m_mode = 1;
         3: m_mode = 0;
         default: ;
      endcase
   endtask

   function automatic logic [17:0] m_exp();
      case (m_mode)
         1: case (m_steps[m_idx])
               1: return ev(1, 1, 'h40, 1, 1, 0, 0);
               2: return ev(2, 2, 'h20, 1, 1, 0, 0);
               3: return ev(3, 0, 0,    1, 1, 0, 0);
               4: return ev(4, 2, 'h18, 1, 1, 0, 0);
               default: return ev(5, 3, 'hC0, 1, 1, 0, 0);
            endcase
         2: return ev(6, 0, 0, 1, 0, 0, 0);
         3: return ev(7, 0, 0, 0, 0, 1, 0);
         4: return ev(7, 0, 0, 0, 0, 0, 1);
         default: return '0;
      endcase
   endfunction

   // ---------------- vector table
   typedef struct {
      bit          st;
      logic [1:0]  pg;
      bit          dr, ps, wf, we;
      int          n;
      logic [17:0] exp;
   } vec_t;

   vec_t tbl[12];

   initial begin
      int n, last, exp_seq[$], seq[$];
      int err_run;

      tbl[0]  = '{1, 2'd0, 1, 0, 0, 0, 1,  ev(1, 1, 'h40, 1, 1, 0, 0)};
      tbl[1]  = '{0, 2'd0, 1, 0, 0, 0, 4,  ev(1, 1, 'h40, 1, 1, 0, 0)};
      tbl[2]  = '{0, 2'd0, 1, 0, 1, 0, 1,  ev(2, 2, 'h20, 1, 1, 0, 0)};
      tbl[3]  = '{0, 2'd0, 1, 0, 0, 0, 12, ev(2, 2, 'h20, 1, 1, 0, 0)};
      tbl[4]  = '{0, 2'd0, 1, 0, 0, 0, 1,  ev(3, 0, 0, 1, 1, 0, 0)};
      tbl[5]  = '{0, 2'd0, 1, 0, 0, 0, 3,  ev(3, 0, 0, 1, 1, 0, 0)};
      tbl[6]  = '{0, 2'd0, 1, 0, 0, 1, 1,  ev(5, 3, 'hC0, 1, 1, 0, 0)};
      tbl[7]  = '{0, 2'd0, 1, 0, 0, 0, 8,  ev(5, 3, 'hC0, 1, 1, 0, 0)};
      tbl[8]  = '{0, 2'd0, 1, 0, 0, 0, 1,  ev(7, 0, 0, 0, 0, 1, 0)};
      tbl[9]  = '{0, 2'd0, 1, 0, 0, 0, 1,  18'h0};
      tbl[10] = '{1, 2'd0, 0, 0, 0, 0, 2,  18'h0};
      tbl[11] = '{1, 2'd3, 1, 0, 0, 0, 2,  18'h0};

      idle_inputs();
      rst = 1;
      cyc(2);
      check_vec("reset", 18'h0);
      rst = 0;
      cyc(1);

      for (int i = 0; i < 12; i++) begin
         start = tbl[i].st; program_sel = tbl[i].pg; door_closed = tbl[i].dr;
         pause = tbl[i].ps; water_full = tbl[i].wf; water_empty = tbl[i].we;
         cyc(tbl[i].n);
         check_vec($sformatf("vec%0d", i), tbl[i].exp);
      end
      idle_inputs();
      cyc(1);

      // heavy program: phase sequence and double-length wash
      start = 1; program_sel = 2'd2;
      cyc(1);
      start = 0;
      last = -1; n = 0;
      for (int i = 0; i < 400; i++) begin
         if (int'(phase) != last) begin seq.push_back(int'(phase)); last = int'(phase); end
         if (phase == 3'd2) n++;
         water_full  = (phase == 3'd1);
         water_empty = (phase == 3'd3);
         if (phase == 3'd0) break;
         cyc(1);
      end
      idle_inputs();
      exp_seq = {1, 2, 3, 1, 4, 3, 1, 4, 3, 5, 7, 0};
      check_int("heavy_wash_len", n, 2 * WT * TD + 1);
      check_int("heavy_seq_len", seq.size(), exp_seq.size());
      for (int i = 0; i < exp_seq.size() && i < seq.size(); i++)
         check_int($sformatf("heavy_seq%0d", i), seq[i], exp_seq[i]);

      // pause in the middle of WASH
      start = 1; program_sel = 2'd0;
      cyc(1);
      start = 0; water_full = 1;
      cyc(1);
      water_full = 0;
      check_vec("wash_entry", ev(2, 2, 'h20, 1, 1, 0, 0));
      cyc(5);
      pause = 1;
      cyc(1);
      check_vec("pause_entry", ev(6, 0, 0, 1, 0, 0, 0));
      cyc(19);
      check_vec("pause_held", ev(6, 0, 0, 1, 0, 0, 0));
      pause = 0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         cyc(1);
         if (phase == 3'd2) n++;
         else break;
      end
      check_int("wash_after_resume", n, 8);
      check_vec("drain_after_pause", ev(3, 0, 0, 1, 1, 0, 0));

      // door opened during SPIN
      water_empty = 1;
      cyc(1);
      water_empty = 0;
      check_vec("spin_entry", ev(5, 3, 'hC0, 1, 1, 0, 0));
      cyc(3);
      door_closed = 0;
      cyc(1);
      check_vec("spin_door_open", ev(6, 0, 0, 1, 0, 0, 0));
      cyc(2);
      door_closed = 1;
      cyc(1);
      check_vec("spin_resume", ev(5, 3, 'hC0, 1, 1, 0, 0));
      for (int i = 0; i < 30 && phase != 3'd7; i++) cyc(1);
      check_vec("done_pulse", ev(7, 0, 0, 0, 0, 1, 0));
      cyc(1);
      check_vec("idle_after_done", 18'h0);

      // fill timeout
      start = 1; program_sel = 2'd1;
      cyc(1);
      start = 0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (phase == 3'd1) n++;
         else break;
         cyc(1);
      end
      check_int("fill_timeout_len", n, FT * TD + 1);
      check_vec("error_state", ev(7, 0, 0, 0, 0, 0, 1));
      start = 1;
      cyc(3);
      check_vec("error_ignores_start", ev(7, 0, 0, 0, 0, 0, 1));
      start = 0;
      rst = 1;
      #1;
      check_vec("error_cleared_by_rst", 18'h0);
      @(negedge clk);
      rst = 0;

      // asynchronous reset mid-WASH
      start = 1; program_sel = 2'd0;
      cyc(1);
      start = 0; water_full = 1;
      cyc(1);
      water_full = 0;
      cyc(3);
      check_vec("wash_before_rst", ev(2, 2, 'h20, 1, 1, 0, 0));
      #2 rst = 1;
      #1;
      check_vec("async_rst_mid_wash", 18'h0);
      @(negedge clk);
      rst = 0;
      idle_inputs();

      // random stimulus against the model
      model_reset();
      err_run = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         check_vec("random", m_exp());
         if (m_mode == 4) err_run++;
         else err_run = 0;
         if (rst) begin
            rst = 0;
         end else if (err_run > 4 || $urandom_range(0, 299) == 0) begin
            rst = 1;
            model_reset();
            err_run = 0;
         end else begin
            start       = ($urandom_range(0, 7) == 0);
            program_sel = 2'($urandom_range(0, 3));
            door_closed = ($urandom_range(0, 29) != 0);
            pause       = ($urandom_range(0, 39) == 0);
            water_full  = ($urandom_range(0, 5) == 0);
            water_empty = ($urandom_range(0, 5) == 0);
         end
         @(posedge clk);
         if (!rst) model_step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wash_cycle_sequencer.md
Name: wash_cycle_sequencer

Overview:
- Upstream control stage for the washing machine datapath.
- Runs the wash program (fill, wash, drain, rinse, spin) as a timed state machine.
- Drives the 3-bit command code and 8-bit operand that feed the command-processing stage's ctrl/data_in inputs.
- Handles door interlock, pause/resume and fill-timeout error.

Parameters:
- TICK_DIV, 16, clk cycles per timer tick (≥2)
- WASH_TICKS, 20, wash phase length in ticks (≥1); doubled for heavy program
- RINSE_TICKS, 10, rinse phase length in ticks (≥1)
- SPIN_TICKS, 8, spin phase length in ticks (≥1)
- FILL_TIMEOUT, 30, max ticks in FILL before error (≥1)
- FILL_LEVEL, 8'h40, operand issued during FILL
- WASH_SPEED, 8'h20, operand during WASH
- RINSE_SPEED, 8'h18, operand during RINSE
- SPIN_SPEED, 8'hC0, operand during SPIN

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  level; request program start
- program  in  2  00 quick (0 rinses), 01 normal (1), 10 heavy (2, double wash), 11 reserved
- door_closed  in  1  door sensor
- pause  in  1  user pause, level
- water_full  in  1  level sensor
- water_empty  in  1  level sensor
- ctrl  out  3  command code to processing stage
- cmd_data  out  8  operand to processing stage
- phase  out  3  current state encoding
- busy  out  1  high in any state except IDLE, DONE, ERROR
- door_lock  out  1  high in FILL/WASH/DRAIN/RINSE/SPIN
- done  out  1  one-cycle pulse on cycle completion
- error  out  1  sticky fill-timeout flag

Behaviour:
- Reset: rst is asynchronous and active-high; clk is the clock. State IDLE; ctrl=0, cmd_data=0, phase=0, busy=0, door_lock=0, done=0, error=0; timer, prescaler and rinse counter = 0. Reset mid-operation aborts immediately.
- States and phase codes: IDLE=0, FILL=1, WASH=2, DRAIN=3, RINSE=4, SPIN=5, PAUSE=6, DONE/ERROR=7. error distinguishes DONE from ERROR.
- Outputs are Moore, decoded from the state register and valid in the same cycle as the state:
  - FILL: ctrl=001, FILL_LEVEL
  - WASH: ctrl=010, WASH_SPEED
  - RINSE: ctrl=010, RINSE_SPEED
  - SPIN: ctrl=011, SPIN_SPEED
  - all other states: ctrl=000, cmd_data=00
- IDLE→FILL when start=1, door_closed=1 and program≠11. Loads rinses_left (0/1/2) and clears the wash flag. Otherwise stay in IDLE.
- Prescaler clears on every state entry and counts clk cycles. tick=1 when prescaler==TICK_DIV-1, then wraps. Tick period is TICK_DIV cycles.
- Timed states (WASH, RINSE, SPIN):
  - Timer loads on entry; heavy WASH loads 2×WASH_TICKS. Timer is 16 bits wide; no overflow at legal parameters.
  - Timer decrements on each tick.
  - When timer==0, leave on the next edge, i.e. entry + D×TICK_DIV + 1 cycles.
- FILL:
  - water_full=1 → WASH if the wash is not yet done, else RINSE.
  - Timer loads FILL_TIMEOUT and decrements on ticks; reaching 0 → ERROR.
  - water_full in the same cycle as timeout: water_full wins.
- WASH/RINSE end → DRAIN. RINSE end decrements rinses_left.
- DRAIN: on water_empty=1 → FILL if rinses_left>0, else SPIN. DRAIN is untimed.
- SPIN end → DONE. DONE lasts 1 cycle with done=1, then → IDLE.
- ERROR: error=1, ctrl=000, held until rst.
- Pause:
  - In any busy state, pause=1 or door_closed=0 → PAUSE.
  - Saves the return state; timer and prescaler freeze.
  - Return to the saved state when pause=0 and door_closed=1; timing resumes from the frozen values.
  - Pause has priority over a same-cycle timer expiry or sensor completion; the expiry is taken after resume.
- start while busy is ignored. start held through DONE re-enters FILL from IDLE only if still asserted in IDLE.

Test Plan:
- TICK_DIV=4, WASH_TICKS=3, program=00, door closed, start pulse, water_full 5 cycles later → ctrl 001/FILL_LEVEL, then 010/WASH_SPEED for exactly 13 cycles. Then DRAIN; water_empty → SPIN 011/C0, then a done pulse and IDLE.
- program=10 → WASH lasts 2×3×4+1=25 cycles; exactly two FILL→RINSE→DRAIN loops (phase 1,4,3 twice) before SPIN.
- pause asserted 5 cycles into WASH for 20 cycles → ctrl=000, phase=6; WASH resumes with remaining 8 cycles; total WASH time 13 cycles excluding the pause.
- door_closed=0 during SPIN → PAUSE, door_lock=0; door closed → SPIN resumes. start with door open in IDLE → no transition.
- FILL with water_full never asserted, FILL_TIMEOUT=2, TICK_DIV=4 → ERROR after 9 cycles, error=1. start ignored; rst clears all outputs to 0.
- program=11 with start → stays IDLE. rst asserted mid-WASH → all outputs 0 asynchronously, phase=0.
